// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver/transmitter family.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // System clocks per oversample tick (integer division)
  function automatic int calc_div(input int sys_clk_freq, input int baud_rate,
                                  input int oversample);
    return sys_clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick at OVERSAMPLE x baud.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 1_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int OVERSAMPLE   = 16
) (
  input  logic sys_clk,
  input  logic areset_n,
  output logic tick
);

  localparam int DIV = calc_div(SYS_CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_div_check
    $error("uart_baud_tick: SYS_CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 1");
  end

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap; never stops
  always_ff @(posedge sys_clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt <= '0;
    end else begin
      cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with valid/ready output register and error flags.
//
// Output handshake: data_out and the flags are meaningful while data_valid=1;
// a frame is delivered on a cycle where data_valid=1 and data_ready=1, and
// data_valid drops on the following cycle unless a new frame commits then.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int      SYS_CLK_FREQ = 1_000_000,
  parameter int      BAUD_RATE    = 9600,
  parameter int      DATA_WIDTH   = 8,
  parameter int      OVERSAMPLE   = 16,
  parameter parity_e PARITY       = PARITY_NONE,
  parameter int      STOP_BITS    = 1
) (
  input  logic                  sys_clk,
  input  logic                  areset_n,
  input  logic                  data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy,
  output rx_state_e             dbg_state
);

  localparam int   SW      = $clog2(OVERSAMPLE);
  localparam int   BW      = $clog2(DATA_WIDTH + 1);
  localparam logic PAR_EN  = (PARITY != PARITY_NONE);
  localparam logic PAR_ODD = (PARITY == PARITY_ODD);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_dw_check
    $error("uart_rx_os: DATA_WIDTH must be 5..9");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_os_check
    $error("uart_rx_os: OVERSAMPLE must be even and at least 4");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
    $error("uart_rx_os: STOP_BITS must be 1 or 2");
  end

  logic                  tick;
  logic                  sync1, sync2, rx;
  rx_state_e             state, state_next;
  logic [SW-1:0]         sample_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  perr_acc, ferr_acc;
  logic                  sample_done, start_mid, last_data_bit, last_stop;
  logic                  commit;

  uart_baud_tick #(
    .SYS_CLK_FREQ(SYS_CLK_FREQ),
    .BAUD_RATE   (BAUD_RATE),
    .OVERSAMPLE  (OVERSAMPLE)
  ) u_tick (
    .sys_clk (sys_clk),
    .areset_n(areset_n),
    .tick    (tick)
  );

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge sys_clk or negedge areset_n) begin
    if (!areset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= data_in;
      sync2 <= sync1;
    end
  end

  assign rx            = sync2;
  assign sample_done   = (sample_cnt == SW'(OVERSAMPLE - 1));
  assign start_mid     = (sample_cnt == SW'(OVERSAMPLE / 2 - 1));
  assign last_data_bit = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign last_stop     = (STOP_BITS == 1) || stop_cnt;

  // FSM state register
  always_ff @(posedge sys_clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; moves only on ticks
  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        IDLE:  if (!rx) state_next = START;
        START: if (start_mid) state_next = rx ? IDLE : DATA;
        DATA:  if (sample_done && last_data_bit)
                 state_next = PAR_EN ? uart_pkg::PARITY : STOP;
        uart_pkg::PARITY: if (sample_done) state_next = STOP;
        STOP:  if (sample_done && last_stop) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM outputs: busy flag, debug state and the frame-commit strobe
  always_comb begin
    busy      = (state != IDLE);
    dbg_state = state;
    commit    = tick && (state == STOP) && sample_done && last_stop;
  end

  // Sample/bit counters, data shift register and error accumulators
  always_ff @(posedge sys_clk or negedge areset_n) begin
    if (!areset_n) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shift_reg  <= '0;
      perr_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          sample_cnt <= '0;
          bit_cnt    <= '0;
          stop_cnt   <= 1'b0;
          perr_acc   <= 1'b0;
          ferr_acc   <= 1'b0;
        end
        START: sample_cnt <= start_mid ? '0 : sample_cnt + 1'b1;
        DATA: begin
          if (sample_done) begin
            sample_cnt <= '0;
            shift_reg  <= {rx, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt    <= bit_cnt + 1'b1;
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
        uart_pkg::PARITY: begin
          if (sample_done) begin
            sample_cnt <= '0;
            perr_acc   <= (((^shift_reg) ^ rx) != PAR_ODD);
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
        STOP: begin
          if (sample_done) begin
            sample_cnt <= '0;
            stop_cnt   <= 1'b1;
            if (!rx) ferr_acc <= 1'b1;
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
        default: sample_cnt <= '0;
      endcase
    end
  end

  // Output register: load on commit (flagging overrun), release on accept
  always_ff @(posedge sys_clk or negedge areset_n) begin
    if (!areset_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit) begin
      data_out   <= shift_reg;
      parity_err <= perr_acc;
      frame_err  <= ferr_acc | ~rx;
      data_valid <= 1'b1;
      overrun    <= data_valid & ~data_ready;
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three receivers (8N1, 8E1, 8O2) on separate lines,
// frames scored through per-receiver expected queues.
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int BIT = 160;

  logic       clk;
  logic       areset_n;
  logic       ready;
  logic       line [3];
  logic [7:0] dout [3];
  logic       dv   [3];
  logic       perr [3];
  logic       ferr [3];
  logic       ovr  [3];
  logic       bsy  [3];
  rx_state_e  st   [3];

  int par_en [3] = '{0, 1, 1};
  int odd_p  [3] = '{0, 0, 1};
  int nstop  [3] = '{1, 1, 2};

  logic [10:0] exp_q [3][$];
  bit          gap_chk [3];
  int          checks   = 0;
  int          failures = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_rx_os #(.SYS_CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .DATA_WIDTH(8),
               .OVERSAMPLE(16), .PARITY(PARITY_NONE), .STOP_BITS(1)) u_dut0 (
    .sys_clk(clk), .areset_n(areset_n), .data_in(line[0]), .data_out(dout[0]),
    .data_valid(dv[0]), .data_ready(ready), .parity_err(perr[0]), .frame_err(ferr[0]),
    .overrun(ovr[0]), .busy(bsy[0]), .dbg_state(st[0]));

  uart_rx_os #(.SYS_CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .DATA_WIDTH(8),
               .OVERSAMPLE(16), .PARITY(PARITY_EVEN), .STOP_BITS(1)) u_dut1 (
    .sys_clk(clk), .areset_n(areset_n), .data_in(line[1]), .data_out(dout[1]),
    .data_valid(dv[1]), .data_ready(ready), .parity_err(perr[1]), .frame_err(ferr[1]),
    .overrun(ovr[1]), .busy(bsy[1]), .dbg_state(st[1]));

  uart_rx_os #(.SYS_CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .DATA_WIDTH(8),
               .OVERSAMPLE(16), .PARITY(PARITY_ODD), .STOP_BITS(2)) u_dut2 (
    .sys_clk(clk), .areset_n(areset_n), .data_in(line[2]), .data_out(dout[2]),
    .data_valid(dv[2]), .data_ready(ready), .parity_err(perr[2]), .frame_err(ferr[2]),
    .overrun(ovr[2]), .busy(bsy[2]), .dbg_state(st[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: parity bit that makes the frame correct
  function automatic logic good_par(input int k, input logic [7:0] d);
    return (odd_p[k] != 0) ? ~(^d) : (^d);
  endfunction

  // reference model: expected {overrun, frame_err, parity_err, data}
  task automatic expect_frame(input int k, input logic [7:0] d, input logic pbit,
                              input logic s1, input logic s2);
    logic pe, fe;
    pe = (par_en[k] != 0) ? (((^d) ^ pbit) != (odd_p[k] != 0)) : 1'b0;
    fe = !s1 || (nstop[k] == 2 && !s2);
    if (!ready && exp_q[k].size() > 0) begin
      void'(exp_q[k].pop_back());
      exp_q[k].push_back({1'b1, fe, pe, d});
    end else begin
      exp_q[k].push_back({1'b0, fe, pe, d});
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input int k, input logic b);
    line[k] = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int k, input logic [7:0] d, input logic pbit,
                            input logic s1, input logic s2);
    drive_bit(k, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(k, d[i]);
    if (par_en[k] != 0) drive_bit(k, pbit);
    drive_bit(k, s1);
    if (nstop[k] == 2) drive_bit(k, s2);
    line[k] = 1'b1;
  endtask

  task automatic frame(input int k, input logic [7:0] d, input logic pbit,
                       input logic s1, input logic s2, input int gap_bits);
    expect_frame(k, d, pbit, s1, s2);
    send_frame(k, d, pbit, s1, s2);
    idle(gap_bits * BIT);
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_data%0d", tag, k), dout[k], 0);
      check($sformatf("%s_valid%0d", tag, k), dv[k], 0);
      check($sformatf("%s_perr%0d", tag, k), perr[k], 0);
      check($sformatf("%s_ferr%0d", tag, k), ferr[k], 0);
      check($sformatf("%s_ovr%0d", tag, k), ovr[k], 0);
      check($sformatf("%s_busy%0d", tag, k), bsy[k], 0);
    end
  endtask

  // scoreboard monitor: compare every delivered frame against the queue
  always @(negedge clk) begin
    if (areset_n) begin
      for (int k = 0; k < 3; k++) begin
        if (gap_chk[k]) begin
          check($sformatf("valid_pulse%0d", k), dv[k], 0);
          gap_chk[k] = 1'b0;
        end
        if (dv[k] && ready) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame%0d: got data %0h, expected no frame", k, dout[k]);
          end else begin
            check($sformatf("frame%0d", k), {ovr[k], ferr[k], perr[k], dout[k]},
                  exp_q[k].pop_front());
          end
          gap_chk[k] = 1'b1;
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [7:0] d;
    logic       pb, s1, s2;
    int         k;
    areset_n = 1'b1;
    ready    = 1'b1;
    for (int i = 0; i < 3; i++) line[i] = 1'b1;
    @(posedge clk);
    #1;
    areset_n = 1'b0;
    idle(3);
    check_all_zero("rst");
    for (int i = 0; i < 3; i++) check($sformatf("rst_state%0d", i), st[i], IDLE);
    areset_n = 1'b1;
    idle(20);

    // basic 8N1 frame, busy only during the frame
    check("t1_busy_before", bsy[0], 0);
    fork
      frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, 2);
      begin
        idle(800);
        check("t1_busy_mid", bsy[0], 1);
      end
    join
    check("t1_busy_after", bsy[0], 0);

    // parity
    frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 2);
    frame(1, 8'h07, 1'b0, 1'b1, 1'b1, 2);
    frame(2, 8'h07, 1'b0, 1'b1, 1'b1, 2);

    // framing error on second stop bit, then a clean frame
    frame(2, 8'h3C, good_par(2, 8'h3C), 1'b1, 1'b0, 2);
    frame(2, 8'h81, good_par(2, 8'h81), 1'b1, 1'b1, 2);

    // start-bit glitch rejection
    line[0] = 1'b0;
    idle(40);
    check("t4_busy_glitch", bsy[0], 1);
    idle(8);
    line[0] = 1'b1;
    idle(BIT);
    check("t4_busy_after", bsy[0], 0);
    check("t4_valid", dv[0], 0);
    frame(0, 8'h55, 1'b0, 1'b1, 1'b1, 2);

    // overrun
    ready = 1'b0;
    frame(0, 8'h11, 1'b0, 1'b1, 1'b1, 0);
    check("t5_valid1", dv[0], 1);
    check("t5_ovr1", ovr[0], 0);
    check("t5_data1", dout[0], 8'h11);
    frame(0, 8'h22, 1'b0, 1'b1, 1'b1, 2);
    check("t5_valid2", dv[0], 1);
    check("t5_ovr2", ovr[0], 1);
    check("t5_data2", dout[0], 8'h22);
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
    check("t5_valid_acc", dv[0], 0);
    check("t5_ovr_acc", ovr[0], 0);
    ready = 1'b1;
    idle(20);

    // reset in the middle of data bit 4
    fork
      send_frame(0, 8'hF0, 1'b0, 1'b1, 1'b1);
      begin
        idle(850);
        check("t6_busy_pre", bsy[0], 1);
        areset_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        idle(5);
        areset_n = 1'b1;
      end
    join
    idle(2 * BIT);
    frame(0, 8'h3C, 1'b0, 1'b1, 1'b1, 2);

    // randomized frames on all receivers
    for (int i = 0; i < 12; i++) begin
      k  = i % 3;
      d  = 8'($urandom_range(0, 255));
      pb = good_par(k, d) ^ ($urandom_range(0, 3) == 0);
      s1 = ($urandom_range(0, 5) != 0);
      s2 = ($urandom_range(0, 5) != 0);
      frame(k, d, pb, s1, s2, 2);
    end

    idle(400);
    for (int i = 0; i < 3; i++) check($sformatf("drain%0d", i), exp_q[i].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised oversampling UART receiver; successor to the single-rate receiver.
- Samples the serial line at OVERSAMPLE× baud with a 2-FF synchroniser, validates the start bit at mid-bit and samples each bit at its centre.
- Supports configurable data width, parity mode and stop-bit count.
- Delivers each frame through a valid/ready output register with parity, framing and overrun flags, for the host-side command/data path.

Parameters:
- SYS_CLK_FREQ, 1_000_000: system clock frequency, Hz.
- BAUD_RATE, 9600: line rate, bit/s.
- DATA_WIDTH, 8: data bits per frame, 5..9, transmitted LSB first.
- OVERSAMPLE, 16: ticks per bit; even, ≥4.
- PARITY, PARITY_NONE: PARITY_NONE, PARITY_EVEN or PARITY_ODD (uart_pkg::parity_e).
- STOP_BITS, 1: 1 or 2.

Ports:
- sys_clk  in  1  system clock; the only clock.
- areset_n  in  1  asynchronous active-low reset.
- data_in  in  1  serial line, asynchronous; idles high.
- data_out  out  DATA_WIDTH  received word.
- data_valid  out  1  data_out and the flags hold an undelivered frame.
- data_ready  in  1  consumer accepts when data_valid=1 and data_ready=1.
- parity_err  out  1  parity mismatch for the held frame; 0 when PARITY_NONE.
- frame_err  out  1  any stop bit sampled 0 for the held frame.
- overrun  out  1  held frame overwrote an unaccepted frame.
- busy  out  1  frame reception in progress, state != IDLE.

Behaviour:
- Reset, asynchronous, areset_n=0:
  - state=IDLE; tick divider, sample counter, bit counter and shift register cleared.
  - Synchroniser flops set to 1.
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - Applies at any point, including mid-frame; the partial frame is discarded.
- Tick generator:
  - DIV = SYS_CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division, elaboration error if <1.
  - Counter runs 0..DIV-1; a 1-cycle tick pulses at DIV-1. Free-running.
- All FSM actions below occur on tick cycles only; rx = synchronised data_in (2-cycle latency).
- IDLE:
  - rx=0 → START, with sample count cleared.
- START:
  - At sample count OVERSAMPLE/2-1, rx=0 → DATA with count cleared; rx=1 → IDLE (glitch rejected, nothing reported).
- DATA:
  - At count OVERSAMPLE-1, shift rx in at the MSB (LSB-first assembly) and increment the bit counter.
  - After DATA_WIDTH bits → PARITY if enabled, else STOP.
- PARITY:
  - Sample at OVERSAMPLE-1.
  - perr = (XOR of data bits ^ sampled bit) != (PARITY==PARITY_ODD).
  - → STOP.
- STOP:
  - Sample each stop bit at OVERSAMPLE-1; any 0 sets ferr.
  - After the final stop sample, commit the frame and → IDLE in the same tick, so a start bit directly following is detected.
- Commit, registered on the cycle after the final stop tick:
  - Load data_out, parity_err, frame_err and set data_valid=1.
  - Frames with errors are still delivered, flags set.
- Handshake:
  - data_valid falls on the cycle after data_valid & data_ready; the other outputs hold their values.
- Commit while data_valid=1 and not accepted that cycle: data_out and flags are overwritten, overrun=1.
- Commit in the same cycle as an accept: new frame loaded, data_valid stays 1, overrun=0.
- overrun clears on accept.
- Counter widths: $clog2(DIV), $clog2(OVERSAMPLE), $clog2(DATA_WIDTH+1); no wrap beyond the terminal counts.

Decomposition:
- uart_pkg holds:
  - parity_e enum: PARITY_NONE, PARITY_EVEN, PARITY_ODD.
  - rx_state_e enum: IDLE, START, DATA, PARITY, STOP.
  - function computing DIV.
- Sub-module uart_baud_tick (parameters SYS_CLK_FREQ, BAUD_RATE, OVERSAMPLE; ports sys_clk, areset_n, tick); reusable by the transmitter.

Test Plan:
Common bench setup: SYS_CLK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16, so DIV=10 and bit=160 cycles; data_ready=1 unless noted.
1. Frame 0xA5, PARITY_NONE, 1 stop → data_out=0xA5, data_valid pulses one cycle, parity_err=0, frame_err=0, busy high only during the frame.
2. PARITY_EVEN:
   - 0x07 with parity bit 1 → data_out=0x07, parity_err=0.
   - Repeat with parity bit 0 → data_out=0x07, parity_err=1.
   - PARITY_ODD, 0x07 with parity bit 0 → parity_err=0.
3. STOP_BITS=2, 0x3C, second stop bit driven 0 → data_out=0x3C, frame_err=1; next clean frame 0x81 → frame_err=0.
4. 48-cycle low glitch on an idle line → busy rises then falls, data_valid stays 0; a following frame 0x55 is received correctly.
5. data_ready=0; frames 0x11 then 0x22 back to back:
   - After the first: data_valid=1, overrun=0.
   - After the second: data_out=0x22, overrun=1.
   - Assert data_ready one cycle → data_valid=0, overrun=0.
6. areset_n pulsed low during data bit 4 of frame 0xF0 → all outputs 0 immediately and no frame delivered; a following frame 0x3C yields data_out=0x3C with no flags.
